// File: rtl/instr_trace_buf.sv
// Instruction retire trace FIFO: captures one record per retired instruction, drops on full.
// Optional per-record cycle timestamp is built only when TRACE_TIMESTAMP_EN is defined.
module instr_trace_buf #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_retired,
    input  logic [31:0]                pc_wb,
    input  logic [31:0]                instr_wb,
    input  logic [4:0]                 rd_wb,
    input  logic [31:0]                rd_val_wb,
    input  logic [5:0]                 type_wb,
    input  logic                       clear_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_rd_val,
    output logic [2:0]                 out_type,
    output logic [31:0]                out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0] pc_mem     [DEPTH];
    logic [31:0] instr_mem  [DEPTH];
    logic [4:0]  rd_mem     [DEPTH];
    logic [31:0] rd_val_mem [DEPTH];
    logic [2:0]  type_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [2:0]    type_enc;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
    assign push      = instr_retired && (!full || pop);
    assign drop      = instr_retired && full && !pop;

    always_comb begin
        type_enc = 3'd7;
        if      (type_wb[0]) type_enc = 3'd0;
        else if (type_wb[1]) type_enc = 3'd1;
        else if (type_wb[2]) type_enc = 3'd2;
        else if (type_wb[3]) type_enc = 3'd3;
        else if (type_wb[4]) type_enc = 3'd4;
        else if (type_wb[5]) type_enc = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]     <= pc_wb;
            instr_mem[wr_ptr]  <= instr_wb;
            rd_mem[wr_ptr]     <= rd_wb;
            rd_val_mem[wr_ptr] <= rd_val_wb;
            type_mem[wr_ptr]   <= type_enc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new drop wins over clear_ovf so no overflow event is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop)           overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_pc     = pc_mem[rd_ptr];
    assign out_instr  = instr_mem[rd_ptr];
    assign out_rd     = rd_mem[rd_ptr];
    assign out_rd_val = rd_val_mem[rd_ptr];
    assign out_type   = type_mem[rd_ptr];

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_ptr] <= ts_cnt;
    end

    assign out_ts = ts_mem[rd_ptr];
`else
    assign out_ts = 32'h0;
`endif

endmodule

// File: tb/tb_instr_trace_buf.sv
// Directed self-checking bench for instr_trace_buf (DEPTH=16); follows TRACE_TIMESTAMP_EN.
module tb_instr_trace_buf;

    logic        clk;
    logic        reset;
    logic        instr_retired;
    logic [31:0] pc_wb;
    logic [31:0] instr_wb;
    logic [4:0]  rd_wb;
    logic [31:0] rd_val_wb;
    logic [5:0]  type_wb;
    logic        clear_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rd;
    logic [31:0] out_rd_val;
    logic [2:0]  out_type;
    logic [31:0] out_ts;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    instr_trace_buf #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .instr_retired(instr_retired),
        .pc_wb(pc_wb), .instr_wb(instr_wb), .rd_wb(rd_wb), .rd_val_wb(rd_val_wb),
        .type_wb(type_wb), .clear_ovf(clear_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd),
        .out_rd_val(out_rd_val), .out_type(out_type), .out_ts(out_ts), .count(count),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_retired = 1'b0;
        out_ready     = 1'b0;
        clear_ovf     = 1'b0;
        pc_wb = '0; instr_wb = '0; rd_wb = '0; rd_val_wb = '0; type_wb = '0;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [5:0] ty);
        instr_retired = 1'b1;
        pc_wb     = pc;
        instr_wb  = pc ^ 32'hA5A5_0000;
        rd_wb     = pc[6:2];
        rd_val_wb = pc + 32'd7;
        type_wb   = ty;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
        chk_cnt++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0 || drop_cnt !== 16'd0)
            $display("FAIL reset_ovf got=%b/%0d exp=0/0", overflow, drop_cnt); else pass_cnt++;
        // Mid-operation reset must drop stored records immediately, without a clock edge.
        for (int i = 0; i < 3; i++) begin
            set_rec(32'h200 + 32'(i), 6'b000001);
            step();
        end
        idle_inputs();
        chk_cnt++; if (count !== 5'd3) $display("FAIL pre_reset_count got=%0d exp=3", count); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        chk_cnt++; if (count !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL async_reset got=%0d/%b exp=0/0", count, out_valid); else pass_cnt++;
        step();
        reset = 1'b0;
        set_rec(32'h777, 6'b000001);
        step();
        idle_inputs();
        chk_cnt++; if (count !== 5'd1 || out_pc !== 32'h777)
            $display("FAIL first_push_after_reset got=%0d/%h exp=1/777", count, out_pc); else pass_cnt++;
    endtask

    task automatic test_single_push();
        do_reset();
        instr_retired = 1'b1;
        pc_wb = 32'h100; instr_wb = 32'h0050_0093; rd_wb = 5'd1; rd_val_wb = 32'd5; type_wb = 6'b000010;
        step();
        idle_inputs();
        chk_cnt++; if (out_valid !== 1'b1 || count !== 5'd1)
            $display("FAIL single_valid got=%b/%0d exp=1/1", out_valid, count); else pass_cnt++;
        chk_cnt++; if (out_type !== 3'd1 || out_rd_val !== 32'd5)
            $display("FAIL single_fields got type=%0d val=%0d exp=1/5", out_type, out_rd_val); else pass_cnt++;
        chk_cnt++; if (out_pc !== 32'h100 || out_instr !== 32'h0050_0093 || out_rd !== 5'd1)
            $display("FAIL single_pc got=%h/%h/%0d exp=100/00500093/1", out_pc, out_instr, out_rd); else pass_cnt++;
        out_ready = 1'b1;
        step();
        chk_cnt++; if (out_valid !== 1'b0 || count !== 5'd0)
            $display("FAIL single_pop got=%b/%0d exp=0/0", out_valid, count); else pass_cnt++;
        step();
        chk_cnt++; if (count !== 5'd0) $display("FAIL empty_ready got=%0d exp=0", count); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_type_encode();
        logic [5:0] tv [7] = '{6'b000101, 6'b000000, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b110000};
        logic [2:0] te [7] = '{3'd0, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_rec(32'h300 + 32'(4*i), tv[i]);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            chk_cnt++; if (out_type !== te[i] || out_pc !== 32'h300 + 32'(4*i))
                $display("FAIL type_enc[%0d] got=%0d pc=%h exp=%0d pc=%h", i, out_type, out_pc, te[i], 32'h300 + 32'(4*i));
            else pass_cnt++;
            out_ready = 1'b1;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_rec(32'h1000 + 32'(4*i), 6'b000001);
            step();
        end
        idle_inputs();
        chk_cnt++; if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd1)
            $display("FAIL ovf_fill got=%0d/%b/%0d exp=16/1/1", count, overflow, drop_cnt); else pass_cnt++;
        // Full + push + pop: the push is accepted, not dropped.
        set_rec(32'hBEEF0, 6'b000001);
        out_ready = 1'b1;
        step();
        idle_inputs();
        chk_cnt++; if (count !== 5'd16 || drop_cnt !== 16'd1 || out_pc !== 32'h1004)
            $display("FAIL full_pushpop got=%0d/%0d/%h exp=16/1/1004", count, drop_cnt, out_pc); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ep;
            ep = (i == 15) ? 32'hBEEF0 : 32'h1004 + 32'(4*i);
            chk_cnt++; if (out_valid !== 1'b1 || out_pc !== ep)
                $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_pc, ep); else pass_cnt++;
            out_ready = 1'b1;
            step();
        end
        idle_inputs();
        chk_cnt++; if (out_valid !== 1'b0 || count !== 5'd0)
            $display("FAIL drained got=%b/%0d exp=0/0", out_valid, count); else pass_cnt++;
    endtask

    task automatic test_clear_ovf();
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else pass_cnt++;
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk_cnt++; if (overflow !== 1'b0 || drop_cnt !== 16'd1)
            $display("FAIL clear_alone got=%b/%0d exp=0/1", overflow, drop_cnt); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            set_rec(32'h4000 + 32'(4*i), 6'b000010);
            step();
        end
        idle_inputs();
        chk_cnt++; if (count !== 5'd16 || overflow !== 1'b0)
            $display("FAIL refill got=%0d/%b exp=16/0", count, overflow); else pass_cnt++;
        set_rec(32'h5000, 6'b000010);
        clear_ovf = 1'b1;
        step();
        idle_inputs();
        chk_cnt++; if (overflow !== 1'b1 || drop_cnt !== 16'd2 || count !== 5'd16)
            $display("FAIL clear_vs_drop got=%b/%0d/%0d exp=1/2/16", overflow, drop_cnt, count); else pass_cnt++;
    endtask

    task automatic test_timestamp();
        logic [31:0] e0, e1;
`ifdef TRACE_TIMESTAMP_EN
        e0 = 32'd3; e1 = 32'd7;
`else
        e0 = 32'd0; e1 = 32'd0;
`endif
        do_reset();
        step(); step(); step();
        set_rec(32'h600, 6'b000001);
        step();
        idle_inputs();
        step(); step(); step();
        set_rec(32'h604, 6'b000001);
        step();
        idle_inputs();
        chk_cnt++; if (count !== 5'd2 || out_ts !== e0)
            $display("FAIL ts_first got=%0d/%0d exp=2/%0d", count, out_ts, e0); else pass_cnt++;
        out_ready = 1'b1;
        step();
        idle_inputs();
        chk_cnt++; if (out_pc !== 32'h604 || out_ts !== e1)
            $display("FAIL ts_second got=%h/%0d exp=604/%0d", out_pc, out_ts, e1); else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_push();
        test_type_encode();
        test_overflow();
        test_clear_ovf();
        test_timestamp();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_trace_buf.md
INSTR_TRACE_BUF -- requirements
Module: instr_trace_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of trace records held; power of 2, range 2..256.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port instr_retired, input, 1, WB-stage retire strobe; one record offered per asserted cycle.
REQ-005 The block SHALL have ports pc_wb and instr_wb, input, 32 each, retiring PC and instruction word.
REQ-006 The block SHALL have ports rd_wb (input, 5) and rd_val_wb (input, 32), destination index and post-write value.
REQ-007 The block SHALL have port type_wb, input, 6, format flags {J,U,B,S,I,R} (bit0 = R).
REQ-008 The block SHALL have port clear_ovf, input, 1, synchronous clear of overflow status.
REQ-009 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), record handshake toward trace sink.
REQ-010 The block SHALL have outputs out_pc 32, out_instr 32, out_rd 5, out_rd_val 32, out_type 3, out_ts 32: head record fields.
REQ-011 The block SHALL have outputs count (log2(DEPTH)+1 bits), overflow 1, drop_cnt 16.

Function
REQ-012 Push: on a clk edge with instr_retired=1 and buffer not full, the block SHALL write {pc,instr,rd,rd_val,type,ts} at the write pointer.
REQ-013 Type encode SHALL be priority R>I>S>B>U>J -> 0..5; no flag set -> 7; value 6 unused.
REQ-014 Pop: a record SHALL leave the buffer on a clk edge where out_valid=1 and out_ready=1.
REQ-015 out_valid SHALL equal (count != 0); out_* fields SHALL reflect the head entry whenever out_valid=1.
REQ-016 Latency: a record pushed into an empty buffer SHALL appear with out_valid=1 on the cycle after the push edge; no same-cycle bypass.
REQ-017 Simultaneous push and pop SHALL both take effect, count unchanged; this holds when full (push accepted, not dropped).
REQ-018 Full (count==DEPTH) with push and no pop: the record SHALL be discarded, overflow set to 1, drop_cnt incremented.
REQ-019 drop_cnt SHALL saturate at 16'hFFFF.
REQ-020 overflow SHALL be sticky until clear_ovf=1; clear_ovf and a new drop in the same cycle SHALL leave overflow=1.
REQ-021 clear_ovf SHALL NOT alter drop_cnt.
REQ-022 Pointers SHALL wrap modulo DEPTH; out_valid=0 with out_ready=1 SHALL have no effect.
REQ-023 out_* field values while out_valid=0 are don't-care; out_valid SHALL never be X after reset.

Reset
REQ-024 Reset SHALL immediately clear read/write pointers, count, overflow, drop_cnt and timestamp counter; out_valid=0.
REQ-025 Reset mid-operation SHALL discard all stored records; storage contents need not be cleared.
REQ-026 First push SHALL be accepted on the first clk edge after reset deasserts.

Configuration
REQ-027 With macro TRACE_TIMESTAMP_EN defined, a 32-bit free-running cycle counter (0 at reset, wraps) SHALL be stored per record and presented on out_ts.
REQ-028 Without TRACE_TIMESTAMP_EN, no counter or ts storage SHALL be built and out_ts SHALL be tied to 32'h0; all other behaviour identical.

Verification
REQ-029 Reset, single push pc=0x100 instr=0x00500093 rd=1 rd_val=5 type=6'b000010 -> next cycle out_valid=1, out_type=1, out_rd_val=5, count=1.
REQ-030 DEPTH=16, out_ready=0, 17 consecutive pushes -> count=16, overflow=1, drop_cnt=1; drain 16 -> PCs in push order, 17th absent.
REQ-031 Full buffer, push and pop same cycle -> count stays 16, drop_cnt unchanged, new record is last drained.
REQ-032 type_wb=6'b000101 -> out_type=0; type_wb=0 -> out_type=7.
REQ-033 overflow=1, assert clear_ovf alone -> overflow=0, drop_cnt unchanged; clear_ovf coincident with drop -> overflow=1.
REQ-034 TRACE_TIMESTAMP_EN defined, pushes on cycles 3 and 7 after reset -> out_ts 3 then 7; undefined -> out_ts=0.
